// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Desc   : Address map, region and state encodings for mem_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   localparam logic [15:0] ROM_BASE      = 16'hF000;
   localparam int          ROM_SIZE      = 4096;
   localparam int          ROM_AW        = $clog2(ROM_SIZE);
   localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_ROM,
      REG_NONE
   } region_e;

   typedef enum logic {
      IDLE,
      ROM_WAIT
   } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module : mem_ctrl_if
// Desc   : CPU-side bus between a CPU (master) and mem_ctrl (slave).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_ctrl_if;

   logic [15:0] address;
   logic [7:0]  data_out;
   logic        read_en;
   logic [7:0]  data_in;
   logic        ready;
   logic        rom_wr_err;

   modport master (
      output address, data_out, read_en,
      input  data_in, ready, rom_wr_err
   );

   modport slave (
      input  address, data_out, read_en,
      output data_in, ready, rom_wr_err
   );

endinterface

`default_nettype wire

// File: rtl/mem_decode.sv
// ============================================================================
// Module : mem_decode
// Desc   : Combinational address decode into RAM / ROM / unmapped region.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_decode
   import mem_pkg::*;
#(
   parameter  int RAM_DEPTH = 4096,
   localparam int RAM_AW    = $clog2(RAM_DEPTH)
) (
   input  logic [15:0]       address_i,
   output region_e           region_o,
   output logic [RAM_AW-1:0] ram_idx_o,
   output logic [ROM_AW-1:0] rom_idx_o
);

   always_comb begin
      region_o = REG_NONE;
      if (32'(address_i) < RAM_DEPTH) begin
         region_o = REG_RAM;
      end else if (address_i >= ROM_BASE) begin
         region_o = REG_ROM;
      end
   end

   assign ram_idx_o = address_i[RAM_AW-1:0];
   assign rom_idx_o = address_i[ROM_AW-1:0];

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module : mem_ctrl
// Desc   : RAM/ROM memory controller; MEM_ROM_WAIT_EN adds ROM read wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_ctrl
   import mem_pkg::*;
#(
   parameter int RAM_DEPTH = 4096,
   parameter int ROM_WAIT  = 2
) (
   input  logic      ph1,
   input  logic      resetb,
   mem_ctrl_if.slave bus
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);

`ifdef MEM_ROM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic [7:0] RAM [0:RAM_DEPTH-1];
   logic [7:0] ROM [0:ROM_SIZE-1];

   region_e           region;
   logic [RAM_AW-1:0] ram_idx;
   logic [ROM_AW-1:0] rom_idx;

   logic              w_ready;
   logic              w_wait_start;
   logic              w_wait_done;
   logic [ROM_AW-1:0] w_wait_idx;

   logic [7:0] data_in_q, data_in_d;
   logic       rom_wr_err_q, rom_wr_err_d;

   mem_decode #(
      .RAM_DEPTH (RAM_DEPTH)
   ) u_decode (
      .address_i (bus.address),
      .region_o  (region),
      .ram_idx_o (ram_idx),
      .rom_idx_o (rom_idx)
   );

   generate
      if (WAIT_EN && ROM_WAIT > 0) begin : g_wait
         localparam int             CW          = $clog2(ROM_WAIT + 1);
         localparam logic [0:0]     ST_IDLE     = mem_pkg::IDLE;
         localparam logic [0:0]     ST_ROM_WAIT = mem_pkg::ROM_WAIT;

         logic [0:0]        state_q, state_d;
         logic [CW-1:0]     cnt_q, cnt_d;
         logic [ROM_AW-1:0] idx_q, idx_d;

         assign w_ready      = (state_q == ST_IDLE);
         assign w_wait_start = w_ready && bus.read_en && (region == REG_ROM);
         assign w_wait_done  = (state_q == ST_ROM_WAIT) && (cnt_q == CW'(1));
         assign w_wait_idx   = idx_q;

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            idx_d   = idx_q;
            case (state_q)
               ST_IDLE: begin
                  if (w_wait_start) begin
                     state_d = ST_ROM_WAIT;
                     cnt_d   = CW'(ROM_WAIT);
                     idx_d   = rom_idx;
                  end
               end
               default: begin
                  cnt_d = cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_d = ST_IDLE;
                  end
               end
            endcase
         end

         always_ff @(posedge ph1) begin
            if (!resetb) begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               idx_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               idx_q   <= idx_d;
            end
         end
      end else begin : g_nowait
         assign w_ready      = 1'b1;
         assign w_wait_start = 1'b0;
         assign w_wait_done  = 1'b0;
         assign w_wait_idx   = '0;
      end
   endgenerate

   // A ROM read that enters the wait state leaves data_in untouched until the count expires.
   always_comb begin
      data_in_d    = data_in_q;
      rom_wr_err_d = 1'b0;
      if (w_wait_done) begin
         data_in_d = ROM[w_wait_idx];
      end else if (w_ready) begin
         if (bus.read_en) begin
            case (region)
               REG_RAM: data_in_d = RAM[ram_idx];
               REG_ROM: if (!w_wait_start) data_in_d = ROM[rom_idx];
               default: data_in_d = UNMAPPED_DATA;
            endcase
         end else if (region == REG_ROM) begin
            rom_wr_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge ph1) begin
      if (!resetb) begin
         data_in_q    <= 8'h00;
         rom_wr_err_q <= 1'b0;
      end else begin
         data_in_q    <= data_in_d;
         rom_wr_err_q <= rom_wr_err_d;
      end
   end

   always_ff @(posedge ph1) begin
      if (resetb && w_ready && !bus.read_en && (region == REG_RAM)) begin
         RAM[ram_idx] <= bus.data_out;
      end
   end

   assign bus.data_in    = data_in_q;
   assign bus.ready      = w_ready;
   assign bus.rom_wr_err = rom_wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module : tb_mem_ctrl
// Desc   : Scoreboard bench for mem_ctrl; define MEM_ROM_WAIT_EN to cover wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

   localparam int WAITS = 2;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       ready;
      logic       err;
   } exp_t;

   logic ph1;
   logic resetb;
   int   cyc;
   int   n_checks;
   int   n_fail;

   exp_t  exp_q[$];
   string name_q[$];

   mem_ctrl_if bus();

   mem_ctrl #(
      .RAM_DEPTH (4096),
      .ROM_WAIT  (WAITS)
   ) dut (
      .ph1    (ph1),
      .resetb (resetb),
      .bus    (bus)
   );

   initial begin
      ph1 = 1'b0;
      forever #5 ph1 = ~ph1;
   end

   initial cyc = 0;
   always @(posedge ph1) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // Monitor: each edge's outputs are compared against whatever was queued for it.
   always @(negedge ph1) begin
      exp_t  e;
      string nm;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_checks++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: checked at cycle %0d, expected at cycle %0d", nm, cyc, e.cyc);
         end else if (bus.data_in !== e.data || bus.ready !== e.ready ||
                      bus.rom_wr_err !== e.err) begin
            n_fail++;
            $display("FAIL %s: got data_in=%h ready=%b rom_wr_err=%b, expected data_in=%h ready=%b rom_wr_err=%b",
                     nm, bus.data_in, bus.ready, bus.rom_wr_err, e.data, e.ready, e.err);
         end
      end
   end

   task automatic op(input bit rd, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] ed, input logic er, input logic ee,
                     input string nm);
      exp_t e;
      bus.read_en  = rd;
      bus.address  = a;
      bus.data_out = d;
      e.cyc   = cyc + 1;
      e.data  = ed;
      e.ready = er;
      e.err   = ee;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge ph1);
      #1;
   endtask

   task automatic rom_read(input logic [15:0] a, input logic [7:0] ed,
                           input logic [7:0] prev, input string nm);
`ifdef MEM_ROM_WAIT_EN
      for (int i = 0; i < WAITS; i++) begin
         op(1'b1, a, 8'h00, prev, 1'b0, 1'b0, {nm, "_stall"});
      end
`endif
      op(1'b1, a, 8'h00, ed, 1'b1, 1'b0, nm);
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      resetb       = 1'b0;
      bus.address  = 16'h0000;
      bus.read_en  = 1'b1;
      bus.data_out = 8'h00;
      dut.ROM[0]    = 8'hA5;
      dut.ROM[16]   = 8'h3C;
      dut.ROM[4092] = 8'h00;
      dut.ROM[4093] = 8'hF0;

      @(posedge ph1);
      #1;
      op(1'b1, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, "reset_0");
      op(1'b0, 16'hF010, 8'h11, 8'h00, 1'b1, 1'b0, "reset_1");
      resetb = 1'b1;

      op(1'b0, 16'h0050, 8'h88, 8'h00, 1'b1, 1'b0, "ram_wr_hold");
      op(1'b1, 16'h0050, 8'h00, 8'h88, 1'b1, 1'b0, "ram_rd_after_wr");
      chk8("ram80_content", dut.RAM[80], 8'h88);
      op(1'b0, 16'h0000, 8'h77, 8'h88, 1'b1, 1'b0, "ram_wr_0000");
      op(1'b0, 16'h0FFF, 8'h3C, 8'h88, 1'b1, 1'b0, "ram_wr_top");
      op(1'b1, 16'h0FFF, 8'h00, 8'h3C, 1'b1, 1'b0, "ram_rd_top");
      op(1'b1, 16'h1000, 8'h00, 8'hFF, 1'b1, 1'b0, "unmapped_rd_1000");

      rom_read(16'hFFFC, 8'h00, 8'hFF, "rom_rd_fffc");
      rom_read(16'hFFFD, 8'hF0, 8'h00, "rom_rd_fffd");
      rom_read(16'hF000, 8'hA5, 8'hF0, "rom_rd_f000");

      op(1'b0, 16'hF010, 8'h55, 8'hA5, 1'b1, 1'b1, "rom_wr_err_pulse");
      op(1'b1, 16'h0050, 8'h00, 8'h88, 1'b1, 1'b0, "rom_wr_err_clear");
      chk8("rom16_unchanged", dut.ROM[16], 8'h3C);

      op(1'b0, 16'h8000, 8'h12, 8'h88, 1'b1, 1'b0, "unmapped_wr");
      op(1'b1, 16'h8000, 8'h00, 8'hFF, 1'b1, 1'b0, "unmapped_rd_8000");
      chk8("ram0_no_alias", dut.RAM[0], 8'h77);
      chk8("ram80_kept", dut.RAM[80], 8'h88);
      op(1'b1, 16'h0000, 8'h00, 8'h77, 1'b1, 1'b0, "ram_rd_0000");

      resetb = 1'b0;
      op(1'b0, 16'hF010, 8'h55, 8'h00, 1'b1, 1'b0, "midrun_reset");
      resetb = 1'b1;
      op(1'b1, 16'h0050, 8'h00, 8'h88, 1'b1, 1'b0, "first_after_reset");

`ifdef MEM_ROM_WAIT_EN
      op(1'b1, 16'hF000, 8'h00, 8'h88, 1'b0, 1'b0, "wait_enter");
      resetb = 1'b0;
      op(1'b1, 16'hF000, 8'h00, 8'h00, 1'b1, 1'b0, "reset_in_wait");
      resetb = 1'b1;
      op(1'b1, 16'h0000, 8'h00, 8'h77, 1'b1, 1'b0, "rd_after_wait_abort");
      chk8("ram80_after_abort", dut.RAM[80], 8'h88);
`endif

      repeat (2) @(negedge ph1);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
